// File: rtl/uart_rx_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_rx_ctrl_pkg                                       |
// | Description : Shared UART receive types and bit-timing constants.    |
// |               rx_state_t : receive FSM state encoding                |
// |               CLKS_PER_BIT / HALF_BIT : 9600 baud at 50 MHz          |
// |               calc_parity : expected parity bit for a data word      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int CLKS_PER_BIT = 5208;
  localparam int HALF_BIT     = 2604;

  // Parity bit the transmitter should have sent: even parity makes the
  // total count of ones even, odd parity inverts that.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_rx_ctrl_if                                        |
// | Description : CPU-side receive bus of the UART receiver.             |
// |   rx_data    received byte, valid while rx_valid                     |
// |   rx_valid   holding register full                                  |
// |   rx_ready   consumer accepts the byte when rx_valid && rx_ready     |
// |   frame_err  1-cycle pulse, stop bit sampled low                     |
// |   parity_err 1-cycle pulse, parity mismatch                          |
// |   overrun    1-cycle pulse, good byte dropped (holding reg full)     |
// |   busy       receiver is inside a frame or a break                   |
// |   master = receiver side, slave = consumer side                      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    output rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_rx_sync                                           |
// | Description : Multi-flop synchroniser for the asynchronous serial    |
// |               line plus falling-edge detection on the synchronised   |
// |               value.                                                 |
// |   clk, rst_n  clock, asynchronous active-low reset                   |
// |   rx_pin      raw serial line (idle high)                            |
// |   rx_s        synchronised line                                      |
// |   rx_fall     1-cycle strobe on a synchronised 1->0 transition       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_pin,
  output logic rx_s,
  output logic rx_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Flops preset to the idle level so leaving reset never looks like a
  // start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rx_s    = r_sync[SYNC_STAGES-1];
  assign rx_fall = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_rx_ctrl                                           |
// | Description : UART receive controller. Detects the start bit,        |
// |               samples DATA_BITS LSB-first, optional parity and one   |
// |               stop bit on the mid-bit bps_clk strobe, and presents   |
// |               the byte in a 1-entry holding register.                |
// |   clk, rst_n  clock, asynchronous active-low reset                   |
// |   rx_pin      asynchronous serial line, idle high                    |
// |   bps_clk     1-cycle mid-bit sample strobe from bps_module          |
// |   count_sig   enables the bps_module counter (low clears it)         |
// |   bus         CPU-side receive bus (uart_rx_ctrl_if.master)          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter bit PARITY_EN   = 1'b0,
  parameter bit PARITY_ODD  = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx_pin,
  input  logic           bps_clk,
  output logic           count_sig,
  uart_rx_ctrl_if.master bus
);

  localparam int                c_cnt_w    = $clog2(DATA_BITS);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_BITS - 1);

  logic w_rx_s;
  logic w_rx_fall;

  rx_state_t            r_state;
  logic                 r_count_sig;
  logic [c_cnt_w-1:0]   r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;
  logic                 r_busy;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_pin  (rx_pin),
    .rx_s    (w_rx_s),
    .rx_fall (w_rx_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_count_sig  <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;

      // Consumer handshake; a load in STOP below overrides this so a
      // same-cycle consume + load keeps rx_valid high with the new byte.
      if (r_valid && bus.rx_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_rx_fall) begin
            r_state     <= START;
            r_count_sig <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        START: begin
          if (bps_clk) begin
            if (w_rx_s) begin
              // Line back high at mid start bit: glitch, not a frame.
              r_state     <= IDLE;
              r_count_sig <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
              r_par_err <= 1'b0;
            end
          end
        end

        DATA: begin
          if (bps_clk) begin
            // LSB arrives first, so shift in at the top and move down.
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == c_last_bit) begin
              r_state <= PARITY_EN ? PARITY : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (bps_clk) begin
            r_par_err <= (w_rx_s != calc_parity(8'(r_shift), PARITY_ODD));
            r_state   <= STOP;
          end
        end

        STOP: begin
          if (bps_clk) begin
            r_count_sig <= 1'b0;
            if (!w_rx_s) begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end else if (r_par_err) begin
              r_parity_err <= 1'b1;
              r_state      <= IDLE;
              r_busy       <= 1'b0;
            end else if (r_valid && !bus.rx_ready) begin
              r_overrun <= 1'b1;
              r_state   <= IDLE;
              r_busy    <= 1'b0;
            end else begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        BREAK: begin
          // Wait out a held-low line; falling edges cannot occur here.
          r_count_sig <= 1'b0;
          if (w_rx_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_count_sig <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign count_sig      = r_count_sig;
  assign bus.rx_data    = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.parity_err = r_parity_err;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_uart_rx_ctrl                                        |
// | Description : Bench for uart_rx_ctrl. Instance a is 8N1, instance b  |
// |               is 8E1; each has its own bps_module counter model.     |
// |               The bit period is scaled down by 81 (5208 -> 64 clk)   |
// |               so the whole run stays short.                          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

  localparam int BIT_CLKS    = CLKS_PER_BIT / 81;   // 64
  localparam int HALF_CLKS   = BIT_CLKS / 2;        // 32
  localparam int GLITCH_CLKS = 1000 / 81;           // 12

  logic clk;
  logic rst_n;
  logic rx_a, rx_b;
  logic bps_a, bps_b;
  logic count_a, count_b;
  int   cnt_a, cnt_b;

  int n_checks;
  int n_fail;

  uart_rx_ctrl_if #(.DATA_BITS(8)) a_if ();
  uart_rx_ctrl_if #(.DATA_BITS(8)) b_if ();

  uart_rx_ctrl #(
    .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .SYNC_STAGES(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_a), .bps_clk(bps_a),
    .count_sig(count_a), .bus(a_if)
  );

  uart_rx_ctrl #(
    .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .SYNC_STAGES(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_b), .bps_clk(bps_b),
    .count_sig(count_b), .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bps_module models: count while enabled, strobe at mid-bit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_a <= 0;
    else if (!count_a || cnt_a == BIT_CLKS - 1) cnt_a <= 0;
    else cnt_a <= cnt_a + 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_b <= 0;
    else if (!count_b || cnt_b == BIT_CLKS - 1) cnt_b <= 0;
    else cnt_b <= cnt_b + 1;
  end
  assign bps_a = count_a && (cnt_a == HALF_CLKS);
  assign bps_b = count_b && (cnt_b == HALF_CLKS);

  // Scoreboard: expected bytes pushed by stimulus, accepted bytes
  // captured by the monitor, compared inside the tests.
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [7:0] got_q_a[$];
  logic [7:0] got_q_b[$];
  int rd_a, rd_b;

  // Cumulative monitor counters; tests take differences.
  int cyc, last_bps_a, lat_a;
  int vhi_a, vhi_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b, bhi_a;
  logic prev_v_a;

  initial begin
    cyc = 0; last_bps_a = 0; lat_a = -1; prev_v_a = 1'b0;
    vhi_a = 0; vhi_b = 0; fe_a = 0; fe_b = 0; pe_a = 0; pe_b = 0;
    ov_a = 0; ov_b = 0; bhi_a = 0;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bps_a) last_bps_a <= cyc;
    if (a_if.rx_valid && !prev_v_a) lat_a <= cyc - last_bps_a;
    prev_v_a <= a_if.rx_valid;
    if (a_if.rx_valid)   vhi_a <= vhi_a + 1;
    if (b_if.rx_valid)   vhi_b <= vhi_b + 1;
    if (a_if.frame_err)  fe_a  <= fe_a + 1;
    if (b_if.frame_err)  fe_b  <= fe_b + 1;
    if (a_if.parity_err) pe_a  <= pe_a + 1;
    if (b_if.parity_err) pe_b  <= pe_b + 1;
    if (a_if.overrun)    ov_a  <= ov_a + 1;
    if (b_if.overrun)    ov_b  <= ov_b + 1;
    if (a_if.busy)       bhi_a <= bhi_a + 1;
    if (a_if.rx_valid && a_if.rx_ready) got_q_a.push_back(a_if.rx_data);
    if (b_if.rx_valid && b_if.rx_ready) got_q_b.push_back(b_if.rx_data);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Full frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input bit sel, input logic [7:0] data,
                            input bit with_par, input logic par, input logic stop);
    drive_rx(sel, 1'b0);
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      drive_rx(sel, data[i]);
      wait_clks(BIT_CLKS);
    end
    if (with_par) begin
      drive_rx(sel, par);
      wait_clks(BIT_CLKS);
    end
    drive_rx(sel, stop);
    wait_clks(BIT_CLKS);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1;
    a_if.rx_ready = 1'b0; b_if.rx_ready = 1'b0;
    wait_clks(4);
    n_checks++; if (count_a !== 1'b0) begin n_fail++; $display("FAIL reset_count_sig: got %b expected 0", count_a); end
    n_checks++; if (a_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", a_if.rx_valid); end
    n_checks++; if (a_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", a_if.rx_data); end
    n_checks++; if (a_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_if.busy); end
    n_checks++; if ({a_if.frame_err, a_if.parity_err, a_if.overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_errors: got %b expected 000", {a_if.frame_err, a_if.parity_err, a_if.overrun}); end
    n_checks++; if ({count_b, b_if.rx_valid, b_if.busy} !== 3'b000) begin n_fail++; $display("FAIL reset_b_outputs: got %b expected 000", {count_b, b_if.rx_valid, b_if.busy}); end
    rst_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic test_single;
    int fe0, pe0, ov0, vh0;
    logic [7:0] got, exp;
    fe0 = fe_a; pe0 = pe_a; ov0 = ov_a; vh0 = vhi_a;
    a_if.rx_ready = 1'b1;
    exp_q_a.push_back(8'h55);
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_clks(4);
    n_checks++; if (got_q_a.size() - rd_a !== 1) begin n_fail++; $display("FAIL single_count: got %0d bytes expected 1", got_q_a.size() - rd_a); end
    if (got_q_a.size() > rd_a && exp_q_a.size() > 0) begin
      got = got_q_a[rd_a]; rd_a++; exp = exp_q_a.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL single_data: got %h expected %h", got, exp); end
    end
    n_checks++; if (lat_a !== 1) begin n_fail++; $display("FAIL single_latency: got %0d expected 1", lat_a); end
    n_checks++; if (vhi_a - vh0 !== 1) begin n_fail++; $display("FAIL single_valid_width: got %0d expected 1", vhi_a - vh0); end
    n_checks++; if ((fe_a - fe0) + (pe_a - pe0) + (ov_a - ov0) !== 0) begin n_fail++; $display("FAIL single_errors: got %0d pulses expected 0", (fe_a - fe0) + (pe_a - pe0) + (ov_a - ov0)); end
    n_checks++; if ({count_a, a_if.busy} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got count_sig,busy=%b expected 00", {count_a, a_if.busy}); end
  endtask

  task automatic test_back_to_back;
    int ov0, fe0;
    logic [7:0] got, exp;
    ov0 = ov_a; fe0 = fe_a;
    a_if.rx_ready = 1'b0;
    exp_q_a.push_back(8'hA3);
    send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);   // dropped: register full
    wait_clks(4);
    n_checks++; if (ov_a - ov0 !== 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d pulses expected 1", ov_a - ov0); end
    n_checks++; if (fe_a - fe0 !== 0) begin n_fail++; $display("FAIL b2b_frame_err: got %0d pulses expected 0", fe_a - fe0); end
    n_checks++; if (a_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_held: got %b expected 1", a_if.rx_valid); end
    if (exp_q_a.size() > 0) begin
      n_checks++; if (a_if.rx_data !== exp_q_a[0]) begin n_fail++; $display("FAIL b2b_data_held: got %h expected %h", a_if.rx_data, exp_q_a[0]); end
    end
    a_if.rx_ready = 1'b1;
    wait_clks(1);
    a_if.rx_ready = 1'b0;
    wait_clks(3);
    n_checks++; if (got_q_a.size() - rd_a !== 1) begin n_fail++; $display("FAIL b2b_count: got %0d bytes expected 1", got_q_a.size() - rd_a); end
    if (got_q_a.size() > rd_a && exp_q_a.size() > 0) begin
      got = got_q_a[rd_a]; rd_a++; exp = exp_q_a.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", got, exp); end
    end
    n_checks++; if (a_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_consumed: got %b expected 0", a_if.rx_valid); end
  endtask

  task automatic test_frame_error;
    int fe0, vh0;
    fe0 = fe_a; vh0 = vhi_a;
    a_if.rx_ready = 1'b1;
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    wait_clks(20 * BIT_CLKS);                     // line held low
    n_checks++; if (a_if.busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b expected 1", a_if.busy); end
    n_checks++; if (count_a !== 1'b0) begin n_fail++; $display("FAIL break_count_sig: got %b expected 0", count_a); end
    rx_a = 1'b1;
    wait_clks(6);
    n_checks++; if (a_if.busy !== 1'b0) begin n_fail++; $display("FAIL break_exit: got busy %b expected 0", a_if.busy); end
    n_checks++; if (fe_a - fe0 !== 1) begin n_fail++; $display("FAIL frame_err_pulse: got %0d expected 1", fe_a - fe0); end
    n_checks++; if (vhi_a - vh0 !== 0) begin n_fail++; $display("FAIL frame_err_valid: got %0d valid cycles expected 0", vhi_a - vh0); end
    n_checks++; if (got_q_a.size() - rd_a !== 0) begin n_fail++; $display("FAIL frame_err_bytes: got %0d expected 0", got_q_a.size() - rd_a); end
  endtask

  task automatic test_glitch;
    int bh0, vh0, err0;
    bh0 = bhi_a; vh0 = vhi_a; err0 = fe_a + pe_a + ov_a;
    rx_a = 1'b0;
    wait_clks(GLITCH_CLKS);
    rx_a = 1'b1;
    wait_clks(2 * BIT_CLKS);
    n_checks++; if (bhi_a - bh0 < HALF_CLKS || bhi_a - bh0 > HALF_CLKS + 4) begin n_fail++; $display("FAIL glitch_busy_cycles: got %0d expected %0d..%0d", bhi_a - bh0, HALF_CLKS, HALF_CLKS + 4); end
    n_checks++; if ({a_if.busy, count_a} !== 2'b00) begin n_fail++; $display("FAIL glitch_idle: got busy,count_sig=%b expected 00", {a_if.busy, count_a}); end
    n_checks++; if (vhi_a - vh0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", vhi_a - vh0); end
    n_checks++; if (fe_a + pe_a + ov_a - err0 !== 0) begin n_fail++; $display("FAIL glitch_errors: got %0d expected 0", fe_a + pe_a + ov_a - err0); end
  endtask

  task automatic test_parity;
    int pe0, fe0, vh0;
    logic [7:0] got, exp;
    pe0 = pe_b; fe0 = fe_b; vh0 = vhi_b;
    b_if.rx_ready = 1'b1;
    // 0x07 has three ones, so even parity needs a 1.
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_clks(4);
    n_checks++; if (pe_b - pe0 !== 1) begin n_fail++; $display("FAIL parity_err_pulse: got %0d expected 1", pe_b - pe0); end
    n_checks++; if (vhi_b - vh0 !== 0) begin n_fail++; $display("FAIL parity_err_valid: got %0d expected 0", vhi_b - vh0); end
    exp_q_b.push_back(8'h07);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_clks(4);
    n_checks++; if (pe_b - pe0 !== 1) begin n_fail++; $display("FAIL parity_ok_no_err: got %0d pulses expected 1 total", pe_b - pe0); end
    n_checks++; if (fe_b - fe0 !== 0) begin n_fail++; $display("FAIL parity_frame_err: got %0d expected 0", fe_b - fe0); end
    n_checks++; if (got_q_b.size() - rd_b !== 1) begin n_fail++; $display("FAIL parity_count: got %0d bytes expected 1", got_q_b.size() - rd_b); end
    if (got_q_b.size() > rd_b && exp_q_b.size() > 0) begin
      got = got_q_b[rd_b]; rd_b++; exp = exp_q_b.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL parity_data: got %h expected %h", got, exp); end
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] got, exp;
    logic [7:0] nxt;
    a_if.rx_ready = 1'b0;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);   // held, then lost to reset
    wait_clks(4);
    n_checks++; if ({a_if.rx_valid, a_if.rx_data} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL midrst_pre_held: got %b/%h expected 1/3c", a_if.rx_valid, a_if.rx_data); end
    nxt = 8'h81;
    rx_a = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx_a = nxt[i];
      wait_clks(BIT_CLKS);
    end
    rx_a = nxt[4];
    wait_clks(HALF_CLKS);
    n_checks++; if (a_if.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b expected 1", a_if.busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({count_a, a_if.rx_valid, a_if.busy} !== 3'b000) begin n_fail++; $display("FAIL midrst_async: got count_sig,valid,busy=%b expected 000", {count_a, a_if.rx_valid, a_if.busy}); end
    n_checks++; if (a_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", a_if.rx_data); end
    rx_a = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(BIT_CLKS);
    a_if.rx_ready = 1'b1;
    exp_q_a.push_back(8'h81);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    wait_clks(4);
    n_checks++; if (got_q_a.size() - rd_a !== 1) begin n_fail++; $display("FAIL midrst_count: got %0d bytes expected 1", got_q_a.size() - rd_a); end
    if (got_q_a.size() > rd_a && exp_q_a.size() > 0) begin
      got = got_q_a[rd_a]; rd_a++; exp = exp_q_a.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL midrst_data_after: got %h expected %h", got, exp); end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; rd_a = 0; rd_b = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_parity();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
